// File: rtl/t09_obstacle_place_ctrl.sv
// Obstacle placement sequencer: draws a random cell, serially scans the snake body and the
// obstacle map neighbourhood, retries on conflict and commits legal cells via one write port.
module t09_obstacle_place_ctrl #(
  parameter int unsigned MAX_LENGTH = 50,
  parameter int unsigned MAX_OBS    = 15,
  parameter int unsigned MAX_TRIES  = 8
) (
  input  logic       clk,
  input  logic       s_reset,
  input  logic       obstacleFlag,
  input  logic       goodColl,
  input  logic [3:0] randX,
  input  logic [3:0] randY,
  input  logic [7:0] curr_length,
  output logic [5:0] body_rd_idx,
  input  logic [7:0] body_rd_data,
  output logic [7:0] map_rd_addr,
  input  logic       map_rd_data,
  output logic       map_wr_en,
  output logic [7:0] map_wr_addr,
  output logic       map_clear,
  output logic       busy,
  output logic       place_done,
  output logic       place_fail,
  output logic [3:0] obstacleCount
);

  localparam logic [7:0] MaxLen   = 8'(MAX_LENGTH);
  localparam logic [3:0] MaxObs   = 4'(MAX_OBS);
  localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

  typedef enum logic [2:0] {StIdle, StDraw, StScan, StCheck, StCommit} stateT;

  stateT      state;
  logic       pending;
  logic       flagQ;
  logic [7:0] cand;
  logic [3:0] tries;
  logic [5:0] scanIdx;
  logic [2:0] chkIdx;

  function automatic logic inGrid(input logic [3:0] x, input logic [3:0] y);
    return (x >= 4'd1) && (x <= 4'd14) && (y >= 4'd1) && (y <= 4'd10);
  endfunction

  function automatic logic [7:0] cellIdx(input logic [3:0] x, input logic [3:0] y);
    return {4'd0, x} + ({4'd0, y} - 8'd1) * 8'd14;
  endfunction

  logic [3:0] candX, candY, segX, segY;
  logic [7:0] candIdx, chkAddr, scanLen;
  logic       headAdj, scanConflict, gateOk;
  logic [8:0] densLhs, densRhs;

  assign candX   = cand[7:4];
  assign candY   = cand[3:0];
  assign segX    = body_rd_data[7:4];
  assign segY    = body_rd_data[3:0];
  assign candIdx = cellIdx(candX, candY);
  assign scanLen = (curr_length > MaxLen) ? MaxLen : curr_length;

  // Orthogonal neighbours of the head are also off-limits.
  assign headAdj = ((segY == candY) && ((segX == candX + 4'd1) || (candX == segX + 4'd1))) ||
                   ((segX == candX) && ((segY == candY + 4'd1) || (candY == segY + 4'd1)));
  assign scanConflict = (body_rd_data == cand) || ((scanIdx == 6'd0) && headAdj);

  assign densLhs = ({5'd0, obstacleCount} + 9'd1) << 1;
  assign densRhs = {1'b0, curr_length} + 9'd2;
  assign gateOk  = (curr_length < 8'd3) || (densLhs < densRhs);

  // Read order: centre, NW, NE, SW, SE; off-grid diagonals fall back to the centre.
  always_comb begin
    chkAddr = candIdx;
    unique case (chkIdx)
      3'd1: if (candX > 4'd1 && candY > 4'd1) chkAddr = candIdx - 8'd15;
      3'd2: if (candX < 4'd14 && candY > 4'd1) chkAddr = candIdx - 8'd13;
      3'd3: if (candX > 4'd1 && candY < 4'd10) chkAddr = candIdx + 8'd13;
      3'd4: if (candX < 4'd14 && candY < 4'd10) chkAddr = candIdx + 8'd15;
      default: ;
    endcase
  end

  assign body_rd_idx = (state == StScan) ? scanIdx : 6'd0;
  assign map_rd_addr = (state == StCheck) ? chkAddr : 8'd0;

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state         <= StIdle;
      pending       <= 1'b0;
      flagQ         <= 1'b0;
      cand          <= 8'd0;
      tries         <= 4'd0;
      scanIdx       <= 6'd0;
      chkIdx        <= 3'd0;
      obstacleCount <= 4'd0;
      map_wr_en     <= 1'b0;
      map_wr_addr   <= 8'd0;
      map_clear     <= 1'b0;
      busy          <= 1'b0;
      place_done    <= 1'b0;
      place_fail    <= 1'b0;
    end else begin
      flagQ      <= obstacleFlag;
      map_wr_en  <= 1'b0;
      map_clear  <= 1'b0;
      place_done <= 1'b0;
      place_fail <= 1'b0;
      if (!obstacleFlag) begin
        state         <= StIdle;
        busy          <= 1'b0;
        pending       <= 1'b0;
        obstacleCount <= 4'd0;
        map_clear     <= flagQ;
      end else begin
        if (goodColl && state != StIdle) pending <= 1'b1;
        unique case (state)
          StIdle: begin
            if (goodColl || pending) begin
              pending <= 1'b0;
              if (obstacleCount < MaxObs) begin
                tries <= 4'd0;
                state <= StDraw;
                busy  <= 1'b1;
              end
            end
          end
          StDraw: begin
            cand  <= {randX, randY};
            tries <= tries + 4'd1;
            if (!inGrid(randX, randY)) begin
              if (tries + 4'd1 >= MaxTries) begin
                state      <= StIdle;
                busy       <= 1'b0;
                place_fail <= 1'b1;
              end
            end else if (curr_length == 8'd0) begin
              state  <= StCheck;
              chkIdx <= 3'd0;
            end else begin
              state   <= StScan;
              scanIdx <= 6'd0;
            end
          end
          StScan: begin
            if (scanConflict) begin
              if (tries < MaxTries) begin
                state <= StDraw;
              end else begin
                state      <= StIdle;
                busy       <= 1'b0;
                place_fail <= 1'b1;
              end
            end else if ({2'b0, scanIdx} + 8'd1 >= scanLen) begin
              state  <= StCheck;
              chkIdx <= 3'd0;
            end else begin
              scanIdx <= scanIdx + 6'd1;
            end
          end
          StCheck: begin
            if (map_rd_data) begin
              if (tries < MaxTries) begin
                state <= StDraw;
              end else begin
                state      <= StIdle;
                busy       <= 1'b0;
                place_fail <= 1'b1;
              end
            end else if (chkIdx == 3'd4) begin
              if (gateOk) begin
                state         <= StCommit;
                map_wr_en     <= 1'b1;
                map_wr_addr   <= candIdx;
                place_done    <= 1'b1;
                obstacleCount <= obstacleCount + 4'd1;
              end else begin
                state      <= StIdle;
                busy       <= 1'b0;
                place_fail <= 1'b1;
              end
            end else begin
              chkIdx <= chkIdx + 3'd1;
            end
          end
          StCommit: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/t09_obstacle_place_ctrl.md
# t09_obstacle_place_ctrl

Sequencing controller for the obstacle map in snake mode. On each good collision it draws a candidate cell from the random source, then checks it against the snake body and the existing obstacle map over several cycles. It retries on conflict and commits legal cells to the obstacle map through a single write port. It replaces single-cycle, all-segment comparison with a serial scan, so the body and map can live behind narrow read ports.

## Interface
- MAX_LENGTH, 50, snake body capacity (segments)
- MAX_OBS, 15, obstacle count ceiling
- MAX_TRIES, 8, candidate draws per request before giving up
- clk  in  1  system clock
- s_reset  in  1  reset; **synchronous, active-high**
- obstacleFlag  in  1  obstacle mode enable; low = clear and hold idle
- goodColl  in  1  one-cycle pulse: apple eaten, request one placement
- randX, randY  in  4 each  free-running random coordinates, sampled in DRAW
- curr_length  in  8  current snake length
- body_rd_idx  out  6  body segment index to read
- body_rd_data  in  8  {x,y} of segment body_rd_idx, combinational same cycle
- map_rd_addr  out  8  obstacle map cell index
- map_rd_data  in  1  map bit at map_rd_addr, combinational same cycle
- map_wr_en  out  1  write 1 to map_wr_addr this cycle
- map_wr_addr  out  8  cell index to set
- map_clear  out  1  one-cycle pulse: clear entire map
- busy  out  1  high in any state other than IDLE
- place_done  out  1  one-cycle pulse: obstacle committed
- place_fail  out  1  one-cycle pulse: request abandoned
- obstacleCount  out  4  committed obstacles

## Operation
- **Grid.** x ranges 1..14 and y ranges 1..10. The cell index is idx = x + (y-1)*14, in the range 1..140, computed in 8 bits. A candidate outside this range is rejected without any reads and consumes one try.
- **States.** IDLE, DRAW, SCAN, CHECK, COMMIT.
- **IDLE.** Start a request on goodColl (or the pending flag) when obstacleFlag=1 and obstacleCount < MAX_OBS. Clear tries and go to DRAW. Otherwise drop the request.
- **DRAW.** Latch cand = {randX, randY} and increment tries. If out of range, retry. Otherwise go to SCAN with body_rd_idx=0.
- **SCAN.** Reads one segment per cycle, indices 0..curr_length-1. The maximum index is min(curr_length, MAX_LENGTH) - 1. If curr_length=0, SCAN is skipped.
  - Conflict if body_rd_data == cand.
  - At index 0 (head), also conflict if cand is an orthogonal neighbour of the head (same y and x±1, or same x and y±1).
- **CHECK.** Five reads in fixed order: centre, NW, NE, SW, SE. Diagonal offsets are −15, −13, +13, +15. A diagonal that would leave the grid is replaced by the centre index. Any map_rd_data=1 is a conflict.
- **Retry.** On a conflict in SCAN or CHECK, abort immediately. Go to DRAW if tries < MAX_TRIES. Otherwise pulse place_fail and go to IDLE.
- **Density gate.** Evaluated on entry to COMMIT. Commit is allowed if curr_length < 3 or (obstacleCount+1)*2 < curr_length+2, computed in 9 bits. If the gate fails, pulse place_fail with no write and go to IDLE.
- **COMMIT.** map_wr_en=1 and map_wr_addr=idx(cand). Increment obstacleCount and pulse place_done. Next state is IDLE.
- **Pending.** A goodColl arriving while busy sets a 1-deep pending flag. Further pulses are dropped. Pending is consumed on return to IDLE.
- **Mode off.** obstacleFlag=0 in any state sends the FSM to IDLE. It zeroes obstacleCount, clears pending, and pulses map_clear once on the 1→0 edge. No place_done or place_fail is generated.
- **Saturation.** At obstacleCount == MAX_OBS, requests are dropped silently and the count never exceeds MAX_OBS.

## Timing
- Reset values: state=IDLE, obstacleCount=0, pending=0, and body_rd_idx, map_rd_addr, map_wr_addr, map_wr_en, map_clear, busy, place_done, place_fail all 0.
- Reset mid-request abandons the request with no write and no pulse. Reset has priority over all inputs.
- goodColl sampled at edge n: DRAW during cycle n+1, SCAN during n+2..n+1+L (L = scanned length), CHECK for 5 cycles, COMMIT for 1 cycle.
- First-try success latency, from goodColl to place_done: L+7 cycles.
- Each retry adds 1 (DRAW) plus the cycles spent up to and including the conflict cycle.
- All outputs are registered except body_rd_idx and map_rd_addr, which come directly from state and counter registers.
- goodColl in the same cycle as COMMIT sets pending. The new request starts 1 cycle after IDLE is entered.

## Test plan
- **Clean placement.** Reset; obstacleFlag=1, curr_length=3, body {5,5},{4,5},{3,5}, rand={9,7}, empty map; pulse goodColl. Required: place_done 10 cycles later, map_wr_addr=93, obstacleCount=1.
- **Body hit then retry.** rand={4,5} on the first DRAW and {9,7} after. Required: exactly one retry, then commit at 93; place_fail never asserted.
- **Head adjacency and edges.**
  - rand={6,5} next to head {5,5} → retry.
  - rand={1,1} → CHECK reads addresses 1,1,1,1,16.
  - rand={0,3} → rejected without reads.
- **Exhausted tries.** Map bit 93 preset, rand stuck at {9,7}. Required: 8 draws, then place_fail, with no write and obstacleCount unchanged.
- **Density, pending and saturation.**
  - curr_length=4, obstacleCount=2 → place_fail.
  - Two extra goodColl pulses while busy → only one extra placement.
  - At obstacleCount=15, goodColl is ignored and busy stays 0.
- **Mode off mid-SCAN.** Drop obstacleFlag. Required: map_clear pulses once, IDLE the next cycle, obstacleCount=0, no place_done.
